// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Purpose  : PLL-lock qualified reset sequencer releasing STAGES active-low
//            resets in order, with soft-reset re-sequencing.
//            Optional lock watchdog enabled by defining RST_SEQ_WDOG_EN.
// Revision : 1.0
// ============================================================================
module rst_seq #(
    parameter int STAGES       = 3,
    parameter int LOCK_STABLE  = 1024,
    parameter int STAGE_GAP    = 16,
    parameter int SOFT_HOLD    = 64,
    parameter int LOCK_TIMEOUT = 2**20,
    parameter int CNT_W        = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              soft_rst_req,
    output logic [STAGES-1:0] rst_n_out,
    output logic              ready,
    output logic [1:0]        state,
    output logic              lock_timeout
);

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    // RUN and SOFT are distinct internally and fold onto code 3 at the port
    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_STABLE    = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_SOFT      = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_stab_last = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(STAGES - 1);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

    logic [1:0]        r_sync;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [STAGES-1:0] r_rst_n_out;
    logic              r_ready;
    logic [1:0]        r_state_dbg;

    logic              w_lock_s;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [STAGES-1:0] w_rst_nxt;

    assign w_lock_s = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], locked};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst_n_out;
        // Lock loss outranks everything, including a pending soft request
        if (r_state != S_WAIT_LOCK && !w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_rst_nxt   = '0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    w_cnt_nxt = '0;
                    w_rst_nxt = '0;
                    if (w_lock_s) begin
                        w_state_nxt = S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (r_cnt == c_stab_last) begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == c_gap_last) begin
                        w_cnt_nxt = '0;
                        w_rst_nxt = r_rst_n_out | (STAGES'(1) << r_idx);
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_idx_nxt = r_idx + c_idx_one;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                S_RUN: begin
                    if (soft_rst_req) begin
                        w_state_nxt = S_SOFT;
                        w_cnt_nxt   = '0;
                        w_rst_nxt   = '0;
                    end
                end
                S_SOFT: begin
                    if (r_cnt == c_hold_last) begin
                        if (!soft_rst_req) begin
                            w_state_nxt = S_RELEASE;
                            w_cnt_nxt   = '0;
                            w_idx_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_rst_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_n_out <= '0;
            r_ready     <= 1'b0;
            r_state_dbg <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_n_out <= w_rst_nxt;
            r_ready     <= (w_state_nxt == S_RUN);
            r_state_dbg <= (w_state_nxt == S_SOFT) ? 2'd3 : w_state_nxt[1:0];
        end
    end

    assign rst_n_out = r_rst_n_out;
    assign ready     = r_ready;
    assign state     = r_state_dbg;

`ifdef RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] c_to_last = CNT_W'(LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_wd;
    logic             r_lock_timeout;
    logic             w_in_qual;

    assign w_in_qual = (r_state == S_WAIT_LOCK) || (r_state == S_STABLE);

    // Count only while still qualifying lock; any later state zeroes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd           <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            if (w_in_qual) begin
                if (r_wd != c_to_last) begin
                    r_wd <= r_wd + c_cnt_one;
                end
                if (r_wd == c_to_last) begin
                    r_lock_timeout <= 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
            if (w_state_nxt == S_RUN && r_state != S_RUN) begin
                r_lock_timeout <= 1'b0;
            end
        end
    end

    assign lock_timeout = r_lock_timeout;
`else
    // Constant-false for every legal LOCK_TIMEOUT
    assign lock_timeout = (LOCK_TIMEOUT < 1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq
// Purpose  : Self-checking bench for rst_seq against a time-based model.
// Revision : 1.0
// ============================================================================
module tb_rst_seq;

    localparam int STAGES = 3;
    localparam int LS     = 8;
    localparam int GAP    = 4;
    localparam int SH     = 5;
    localparam int LT     = 32;
    localparam int CW     = 6;
    localparam int FULL   = LS + STAGES * GAP;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              locked;
    logic              soft_rst_req;
    logic [STAGES-1:0] rst_n_out;
    logic              ready;
    logic [1:0]        state;
    logic              lock_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: m_t = edges since lock was qualified (-1 while waiting),
    // m_soft = edges since soft reset began (-1 when not in soft reset)
    int         m_t;
    int         m_soft;
    int         m_wd;
    logic       m_to;
    logic [1:0] m_sync;

    rst_seq #(
        .STAGES      (STAGES),
        .LOCK_STABLE (LS),
        .STAGE_GAP   (GAP),
        .SOFT_HOLD   (SH),
        .LOCK_TIMEOUT(LT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .locked      (locked),
        .soft_rst_req(soft_rst_req),
        .rst_n_out   (rst_n_out),
        .ready       (ready),
        .state       (state),
        .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_t    = -1;
        m_soft = -1;
        m_wd   = 0;
        m_to   = 1'b0;
        m_sync = 2'b00;
    endtask

    function automatic logic [STAGES-1:0] exp_rst();
        logic [STAGES-1:0] m;
        int n;
        m = '0;
        if (m_soft < 0 && m_t >= LS) begin
            n = (m_t - LS) / GAP;
            for (int i = 0; i < STAGES; i++) begin
                if (i < n) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic exp_ready();
        return (m_soft < 0 && m_t >= FULL);
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_t < 0)        return 2'd0;
        if (m_soft >= 0)    return 2'd3;
        if (m_t < LS)       return 2'd1;
        if (m_t < FULL)     return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_edge();
        logic lock_s;
        logic pre_qual;
        logic pre_run;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lock_s   = m_sync[1];
        pre_qual = (m_soft < 0 && m_t < LS);
        pre_run  = (m_soft < 0 && m_t >= FULL);
        m_sync   = {m_sync[0], locked};
        if (m_t < 0) begin
            if (lock_s) m_t = 0;
        end else if (!lock_s) begin
            m_t    = -1;
            m_soft = -1;
        end else if (m_soft >= 0) begin
            if (m_soft + 1 >= SH && !soft_rst_req) begin
                m_soft = -1;
                m_t    = LS;
            end else begin
                m_soft++;
            end
        end else if (pre_run) begin
            if (soft_rst_req) m_soft = 0;
        end else begin
            m_t++;
        end
`ifdef RST_SEQ_WDOG_EN
        if (pre_qual) begin
            if (m_wd < LT) m_wd++;
            if (m_wd == LT) m_to = 1'b1;
        end else begin
            m_wd = 0;
        end
        if (!pre_run && exp_ready()) m_to = 1'b0;
`else
        m_wd = pre_qual ? m_wd : 0;
`endif
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rst_n_out", 8'(rst_n_out), 8'(exp_rst()));
        check("ready", 8'(ready), 8'(exp_ready()));
        check("state", 8'(state), 8'(exp_state()));
        check("lock_timeout", 8'(lock_timeout), 8'(m_to));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;

        // Reset state
        rst_n        = 1'b0;
        locked       = 1'b0;
        soft_rst_req = 1'b0;
        model_reset();
        #2;
        check_all();
        ticks(2);

        // Lock present before edge 1: stages at 15/19/23
        rst_n  = 1'b1;
        locked = 1'b1;
        ticks(15);
        check("s1_e15_rst", 8'(rst_n_out), 8'h1);
        ticks(4);
        check("s1_e19_rst", 8'(rst_n_out), 8'h3);
        ticks(4);
        check("s1_e23_rst", 8'(rst_n_out), 8'h7);
        check("s1_e23_ready", 8'(ready), 8'h1);
        ticks(3);

        // Soft-reset pulse of random length; timing fixed for one-cycle pulse
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("s3_k_rst", 8'(rst_n_out), 8'h0);
        check("s3_k_ready", 8'(ready), 8'h0);
        ticks(5);
        check("s3_k5_state", 8'(state), 8'h2);
        ticks(4);
        check("s3_k9_rst", 8'(rst_n_out), 8'h1);
        ticks(8);
        check("s3_k17_ready", 8'(ready), 8'h1);
        soft_rst_req = 1'b1;
        ticks($urandom_range(1, 12));
        soft_rst_req = 1'b0;
        ticks(25);

        // Lock glitch while qualifying
        locked = 1'b0;
        ticks(4);
        locked = 1'b1;
        ticks($urandom_range(4, 8));
        locked = 1'b0;
        tick();
        locked = 1'b1;
        ticks(30);

        // Lock loss while rst_n_out=011; relock repeats the base timing
        locked = 1'b0;
        ticks(3);
        locked = 1'b1;
        ticks(19);
        check("s4_pre_rst", 8'(rst_n_out), 8'h3);
        locked = 1'b0;
        ticks(2);
        check("s4_hold_rst", 8'(rst_n_out), 8'h3);
        tick();
        check("s4_drop_rst", 8'(rst_n_out), 8'h0);
        check("s4_drop_state", 8'(state), 8'h0);
        locked = 1'b1;
        ticks(23);
        check("s4_relock_ready", 8'(ready), 8'h1);

        // Async reset in the middle of RELEASE
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (exp_state() == 2'd2 && m_t >= LS + GAP) found = 1'b1;
        end
        check("s5_reached_release", 8'(found), 8'h1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        ticks(2);
        rst_n = 1'b1;
        ticks(23);
        check("s5_restart_ready", 8'(ready), 8'h1);

        // Randomized lock and soft-reset activity
        for (int i = 0; i < 600; i++) begin
            if (locked && $urandom_range(0, 39) == 0) locked = 1'b0;
            else if (!locked && $urandom_range(0, 2) == 0) locked = 1'b1;
            soft_rst_req = ($urandom_range(0, 7) == 0);
            tick();
        end
        soft_rst_req = 1'b0;

        // Lock held low long enough to trip the watchdog, then recover
        locked = 1'b0;
        ticks(40);
`ifdef RST_SEQ_WDOG_EN
        check("s6_timeout_set", 8'(lock_timeout), 8'h1);
`else
        check("s6_timeout_tied", 8'(lock_timeout), 8'h0);
`endif
        locked = 1'b1;
        ticks(30);
        check("s6_final_ready", 8'(ready), 8'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
